cmp: RTL and testbench

Registered unsigned magnitude comparator for two WIDTH-bit operands, producing one-hot greater/less/equal flags one clock after the operands are presented. It sits in the arithmetic datapath wherever a registered ordering decision between two unsigned buses is needed. An optional cross-check build runs three independent comparator architectures side by side and flags any disagreement.

---
 rtl/cmp.sv | 88 ++++++++
 tb/tb_cmp.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cmp.sv
// cmp: registered unsigned magnitude comparator with one-hot gt/lt/eq flags.
// Define CMP_CROSSCHECK_EN to build subtractor and bit-cascade comparators that drive mismatch.
module cmp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic             mismatch
);
    logic a_gt, a_lt, a_eq;
    logic out_valid_d, gt_d, lt_d, eq_d;
    logic out_valid_q, gt_q, lt_q, eq_q;

    assign a_gt = a > b;
    assign a_lt = a < b;
    assign a_eq = a == b;

    always_comb begin
        out_valid_d = in_valid;
        gt_d        = in_valid ? a_gt : gt_q;
        lt_d        = in_valid ? a_lt : lt_q;
        eq_d        = in_valid ? a_eq : eq_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            gt_q        <= gt_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
        end
    end

    assign out_valid = out_valid_q;
    assign gt        = gt_q;
    assign lt        = lt_q;
    assign eq        = eq_q;

`ifdef CMP_CROSSCHECK_EN
    logic [WIDTH:0] diff;
    logic b_gt, b_lt, b_eq;
    logic c_gt, c_lt, c_eq;
    logic mismatch_d, mismatch_q;

    assign diff = {1'b0, a} - {1'b0, b};
    assign b_lt = diff[WIDTH];
    assign b_eq = diff == '0;
    assign b_gt = ~b_lt & ~b_eq;

    // Scanning upward lets the most significant differing bit overwrite lower ones.
    always_comb begin
        c_gt = 1'b0;
        c_lt = 1'b0;
        for (int i = 0; i < WIDTH; i++)
            if (a[i] != b[i]) begin
                c_gt = a[i];
                c_lt = b[i];
            end
        c_eq = ~c_gt & ~c_lt;
    end

    always_comb begin
        mismatch_d = in_valid & (({b_gt, b_lt, b_eq} != {a_gt, a_lt, a_eq}) |
                                 ({c_gt, c_lt, c_eq} != {a_gt, a_lt, a_eq}));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mismatch_q <= 1'b0;
        else     mismatch_q <= mismatch_d;
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_cmp.sv
// tb_cmp: randomized self-checking bench for cmp against a signed-difference reference model.
module tb_cmp;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       out_valid, gt, lt, eq, mismatch;

    int n_checks = 0;
    int n_fail   = 0;
    logic ev = 1'b0, eg = 1'b0, el = 1'b0, ee = 1'b0;

    cmp #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(out_valid), .gt(gt), .lt(lt), .eq(eq), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    // Drives one cycle, advances the reference model, and leaves time 1 past the edge.
    task automatic step(input logic v, input logic [7:0] x, input logic [7:0] y);
        int d;
        in_valid = v;
        a = x;
        b = y;
        @(posedge clk);
        d = int'(x) - int'(y);
        ev = v;
        if (v) begin
            eg = d > 0;
            el = d < 0;
            ee = d == 0;
        end
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b1;
        a = 8'h05;
        b = 8'h03;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, gt, lt, eq, mismatch} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got %b exp 00000", {out_valid, gt, lt, eq, mismatch});
        end
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h05, 8'h03);
        n_checks++;
        if ({out_valid, gt, lt, eq, mismatch} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_release: got %b exp 11000", {out_valid, gt, lt, eq, mismatch});
        end
        #2 rst = 1'b1;
        #1;
        {ev, eg, el, ee} = 4'b0;
        n_checks++;
        if ({out_valid, gt, lt, eq, mismatch} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_async: got %b exp 00000", {out_valid, gt, lt, eq, mismatch});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned;
        logic [7:0] bs [3] = '{8'h01, 8'hFF, 8'h80};
        logic [4:0] ex [3] = '{5'b11000, 5'b10100, 5'b10010};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h80, bs[i]);
            n_checks++;
            if ({out_valid, gt, lt, eq, mismatch} !== ex[i]) begin
                n_fail++;
                $display("FAIL unsigned_%0d: got %b exp %b", i, {out_valid, gt, lt, eq, mismatch}, ex[i]);
            end
        end
    endtask

    task automatic test_extremes;
        logic [7:0] as [6] = '{8'h00, 8'h00, 8'hFF, 8'h01, 8'h00, 8'hFF};
        logic [7:0] bs [6] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h01, 8'hFF};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, as[i], bs[i]);
            n_checks++;
            if ({out_valid, gt, lt, eq, mismatch} !== {ev, eg, el, ee, 1'b0}) begin
                n_fail++;
                $display("FAIL extreme_%0d a=%h b=%h: got %b exp %b", i, as[i], bs[i],
                         {out_valid, gt, lt, eq, mismatch}, {ev, eg, el, ee, 1'b0});
            end
        end
    endtask

    task automatic test_valid_gating;
        logic [2:0] held;
        step(1'b1, 8'h10, 8'h20);
        held = {gt, lt, eq};
        n_checks++;
        if (held !== 3'b010) begin
            n_fail++;
            $display("FAIL gating_setup: got %b exp 010", held);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'($urandom), 8'($urandom));
            n_checks++;
            if ({out_valid, gt, lt, eq, mismatch} !== {1'b0, 3'b010, 1'b0}) begin
                n_fail++;
                $display("FAIL gating_%0d: got %b exp 00100", i, {out_valid, gt, lt, eq, mismatch});
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(3) != 0, 8'($urandom), 8'($urandom));
            n_checks++;
            if ({out_valid, gt, lt, eq, mismatch} !== {ev, eg, el, ee, 1'b0}) begin
                n_fail++;
                $display("FAIL random_%0d a=%h b=%h: got %b exp %b", i, a, b,
                         {out_valid, gt, lt, eq, mismatch}, {ev, eg, el, ee, 1'b0});
            end
        end
    endtask

`ifdef CMP_CROSSCHECK_EN
    task automatic test_exhaustive;
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, 8'(i >> 8), 8'(i));
            n_checks++;
            if ({out_valid, gt, lt, eq, mismatch} !== {ev, eg, el, ee, 1'b0} ||
                $countones({gt, lt, eq}) != 1) begin
                n_fail++;
                $display("FAIL exhaustive a=%h b=%h: got %b exp %b", a, b,
                         {out_valid, gt, lt, eq, mismatch}, {ev, eg, el, ee, 1'b0});
            end
        end
    endtask
`endif

    initial begin
        test_reset;
        test_unsigned;
        test_extremes;
        test_valid_gating;
        test_random;
`ifdef CMP_CROSSCHECK_EN
        test_exhaustive;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
